// File: rtl/cvxif_sched_pkg.sv
// Shared types for the CV-X-IF instruction scheduler.
//   entry_state_e : lifecycle of one instruction-buffer slot
//   sched_state_e : dispatch FSM states
//   entry_t       : buffer slot layout at the default geometry (ID 4 b, OP 96 b)
package cvxif_sched_pkg;

  localparam int unsigned SCHED_ID_W = 4;
  localparam int unsigned SCHED_OP_W = 96;

  typedef enum logic [1:0] {
    ENTRY_EMPTY     = 2'd0,
    ENTRY_ISSUED    = 2'd1,
    ENTRY_COMMITTED = 2'd2,
    ENTRY_KILLED    = 2'd3
  } entry_state_e;

  typedef enum logic [1:0] {
    SCHED_IDLE     = 2'd0,
    SCHED_DISPATCH = 2'd1,
    SCHED_WAIT     = 2'd2,
    SCHED_RESP     = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_ID_W-1:0] id;
    logic [SCHED_OP_W-1:0] op;
    entry_state_e          state;
  } entry_t;

endpackage

// File: rtl/cvxif_sched_watchdog.sv
// EXU watchdog for the CV-X-IF scheduler.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : clears the counter (dispatch handshake, i.e. WAIT entry)
//   run_i         : high while the scheduler sits in WAIT; counts one per cycle
//   expired_o     : high in the TIMEOUT-th WAIT cycle
// Only instantiated when CVXIF_SCHED_TIMEOUT_EN is defined.
module cvxif_sched_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The counter holds the number of WAIT cycles already completed, so
  // TIMEOUT-1 marks the last permitted cycle.
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cvxif_instr_scheduler.sv
// In-order scheduler between the CV-X-IF issue/commit/result interfaces and a
// single shared coprocessor exec unit (EXU).
//   issue_*  : offload requests; pushed when valid & accept & ready
//   commit_* : commit (kill=0) or kill (kill=1) of a buffered id
//   exu_*    : one-at-a-time dispatch, EXU done is a 1-cycle pulse
//   result_* : results in program order with ready/valid backpressure
// Optional feature macro: CVXIF_SCHED_TIMEOUT_EN enables an EXU watchdog that
// ends WAIT after TIMEOUT cycles with result_exc_o=1 and zero data.
module cvxif_instr_scheduler
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned OP_W    = 96,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  input  logic             issue_accept_i,
  output logic             issue_ready_o,
  input  logic [ID_W-1:0]  issue_id_i,
  input  logic [OP_W-1:0]  issue_op_i,
  input  logic             commit_valid_i,
  input  logic [ID_W-1:0]  commit_id_i,
  input  logic             commit_kill_i,
  output logic             exu_valid_o,
  input  logic             exu_ready_i,
  output logic [OP_W-1:0]  exu_op_o,
  input  logic             exu_done_i,
  input  logic [RES_W-1:0] exu_data_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [ID_W-1:0]  result_id_o,
  output logic [RES_W-1:0] result_data_o,
  output logic             result_exc_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OP_W-1:0] op;
    entry_state_e    state;
  } slot_t;

  slot_t            table_q [DEPTH];
  ptr_t             head_q;
  ptr_t             tail_q;
  cnt_t             count_q;
  sched_state_e     state_q;
  sched_state_e     state_d;
  logic [RES_W-1:0] res_data_q;

  logic         push;
  logic         pop;
  logic         timeout;
  logic         commit_hit;
  ptr_t         commit_idx;
  ptr_t         scan_idx;
  logic         commit_to_new;
  entry_state_e commit_state;

  assign issue_ready_o = (count_q != cnt_t'(DEPTH));
  assign push          = issue_valid_i && issue_ready_o && issue_accept_i;
  assign commit_state  = commit_kill_i ? ENTRY_KILLED : ENTRY_COMMITTED;

  // Oldest-first search so a reused id resolves to the earliest ISSUED entry.
  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + ptr_t'(i);
      if (!commit_hit && (cnt_t'(i) < count_q) &&
          (table_q[scan_idx].state == ENTRY_ISSUED) &&
          (table_q[scan_idx].id == commit_id_i)) begin
        commit_hit = 1'b1;
        commit_idx = scan_idx;
      end
    end
  end

  // A commit that matches nothing already buffered may target the entry being
  // pushed in the same cycle.
  assign commit_to_new = commit_valid_i && push && !commit_hit &&
                         (commit_id_i == issue_id_i);

  assign pop = ((state_q == SCHED_IDLE) && (table_q[head_q].state == ENTRY_KILLED)) ||
               ((state_q == SCHED_RESP) && result_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Commit, push and pop always touch distinct slots: commit needs ISSUED,
      // push needs an EMPTY tail, pop needs a COMMITTED/KILLED head.
      if (commit_valid_i && commit_hit) begin
        table_q[commit_idx].state <= commit_state;
      end
      if (push) begin
        table_q[tail_q].id    <= issue_id_i;
        table_q[tail_q].op    <= issue_op_i;
        table_q[tail_q].state <= commit_to_new ? commit_state : ENTRY_ISSUED;
        tail_q                <= tail_q + ptr_t'(1);
      end
      if (pop) begin
        table_q[head_q].state <= ENTRY_EMPTY;
        head_q                <= head_q + ptr_t'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + cnt_t'(1);
      end else if (!push && pop) begin
        count_q <= count_q - cnt_t'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCHED_IDLE:     if (table_q[head_q].state == ENTRY_COMMITTED) state_d = SCHED_DISPATCH;
      SCHED_DISPATCH: if (exu_ready_i) state_d = SCHED_WAIT;
      SCHED_WAIT:     if (exu_done_i || timeout) state_d = SCHED_RESP;
      SCHED_RESP:     if (result_ready_i) state_d = SCHED_IDLE;
      default:        state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SCHED_IDLE;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SCHED_WAIT) begin
        if (exu_done_i) begin
          res_data_q <= exu_data_i;
        end else if (timeout) begin
          res_data_q <= '0;
        end
      end
    end
  end

`ifdef CVXIF_SCHED_TIMEOUT_EN
  logic res_exc_q;

  cvxif_sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   ((state_q == SCHED_DISPATCH) && exu_ready_i),
    .run_i     (state_q == SCHED_WAIT),
    .expired_o (timeout)
  );

  // A done pulse arriving in the expiry cycle still wins and reports data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_exc_q <= 1'b0;
    end else if (state_q == SCHED_WAIT) begin
      if (exu_done_i) begin
        res_exc_q <= 1'b0;
      end else if (timeout) begin
        res_exc_q <= 1'b1;
      end
    end
  end

  assign result_exc_o = result_valid_o && res_exc_q;
`else
  assign timeout      = 1'b0;
  assign result_exc_o = 1'b0;

  if (TIMEOUT == 0) begin : g_no_watchdog
  end
`endif

  assign exu_valid_o    = (state_q == SCHED_DISPATCH);
  assign exu_op_o       = exu_valid_o ? table_q[head_q].op : '0;
  assign result_valid_o = (state_q == SCHED_RESP);
  assign result_id_o    = result_valid_o ? table_q[head_q].id : '0;
  assign result_data_o  = result_valid_o ? res_data_q : '0;

endmodule

// File: tb/tb_cvxif_instr_scheduler.sv
module tb_cvxif_instr_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i, issue_accept_i, issue_ready_o;
  logic [3:0]  issue_id_i;
  logic [95:0] issue_op_i;
  logic        commit_valid_i, commit_kill_i;
  logic [3:0]  commit_id_i;
  logic        exu_valid_o, exu_ready_i, exu_done_i;
  logic [95:0] exu_op_o;
  logic [31:0] exu_data_i;
  logic        result_valid_o, result_ready_i, result_exc_o;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cvxif_instr_scheduler #(
    .DEPTH   (4),
    .ID_W    (4),
    .OP_W    (96),
    .RES_W   (32),
    .TIMEOUT (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_valid_i  (issue_valid_i),
    .issue_accept_i (issue_accept_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_op_i     (issue_op_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .exu_valid_o    (exu_valid_o),
    .exu_ready_i    (exu_ready_i),
    .exu_op_o       (exu_op_o),
    .exu_done_i     (exu_done_i),
    .exu_data_i     (exu_data_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_data_o  (result_data_o),
    .result_exc_o   (result_exc_o)
  );

  typedef struct {
    logic        iv, ia;
    logic [3:0]  iid;
    logic        cv;
    logic [3:0]  cid;
    logic        ck;
    logic        er, ed;
    logic [31:0] edata;
    logic        rr;
    logic        x_ir, x_ev;
    logic [3:0]  x_opid;
    logic        x_rv;
    logic [3:0]  x_rid;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t vecs [25];

  function automatic logic [95:0] op_of(input logic [3:0] id);
    return {8'hA0, 20'h0, id, 32'h1234_5678, 28'h0, id};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid_i  = 1'b0;
    issue_accept_i = 1'b0;
    issue_id_i     = '0;
    issue_op_i     = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    exu_ready_i    = 1'b0;
    exu_done_i     = 1'b0;
    exu_data_i     = '0;
    result_ready_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_commit(input logic [3:0] id);
    issue_valid_i  = 1'b1;
    issue_accept_i = 1'b1;
    issue_id_i     = id;
    issue_op_i     = op_of(id);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    tick();
    idle_inputs();
  endtask

  task automatic wait_dispatch(input string name);
    int n = 0;
    while (!exu_valid_o && n < 20) begin
      tick();
      n++;
    end
    check(name, exu_valid_o, 1'b1);
  endtask

  // Dispatch the head, return data one WAIT cycle later, hold the result for
  // `hold` cycles with result_ready low, then complete the handshake.
  task automatic drain_one(input logic [3:0] id, input logic [31:0] data, input int hold);
    wait_dispatch("drain_dispatch");
    check("drain_op", exu_op_o, op_of(id));
    exu_ready_i = 1'b1;
    tick();
    exu_ready_i = 1'b0;
    tick();
    exu_done_i = 1'b1;
    exu_data_i = data;
    tick();
    exu_done_i = 1'b0;
    exu_data_i = '0;
    check("drain_rvalid", result_valid_o, 1'b1);
    check("drain_rid", result_id_o, id);
    check("drain_rdata", result_data_o, data);
    check("drain_rexc", result_exc_o, 1'b0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_rvalid", result_valid_o, 1'b1);
      check("hold_rid", result_id_o, id);
      check("hold_rdata", result_data_o, data);
      check("hold_no_dispatch", exu_valid_o, 1'b0);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("drain_rvalid_low", result_valid_o, 1'b0);
  endtask

  initial begin
    //          iv ia iid  cv cid ck  er ed edata   rr   ir ev opid rv rid rdata
    vecs[0]  = '{1, 1, 3,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[1]  = '{0, 0, 0,  1, 3,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[2]  = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      0,   1, 1, 3,   0, 0, 0};
    vecs[3]  = '{0, 0, 0,  0, 0,  0,  1, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[4]  = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[5]  = '{0, 0, 0,  0, 0,  0,  0, 1, 32'h55, 0,   1, 0, 0,   1, 3, 32'h55};
    vecs[6]  = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      1,   1, 0, 0,   0, 0, 0};
    vecs[7]  = '{1, 0, 4,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[8]  = '{0, 0, 0,  1, 4,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[9]  = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[10] = '{1, 1, 1,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[11] = '{1, 1, 2,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[12] = '{0, 0, 0,  1, 1,  1,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[13] = '{0, 0, 0,  1, 2,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[14] = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      0,   1, 1, 2,   0, 0, 0};
    vecs[15] = '{0, 0, 0,  0, 0,  0,  1, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[16] = '{0, 0, 0,  0, 0,  0,  0, 1, 32'h22, 0,   1, 0, 0,   1, 2, 32'h22};
    vecs[17] = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      1,   1, 0, 0,   0, 0, 0};
    vecs[18] = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[19] = '{1, 1, 7,  1, 7,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[20] = '{0, 0, 0,  1, 9,  0,  0, 0, 0,      0,   1, 1, 7,   0, 0, 0};
    vecs[21] = '{0, 0, 0,  0, 0,  0,  1, 1, 32'h99, 0,   1, 0, 0,   0, 0, 0};
    vecs[22] = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      0,   1, 0, 0,   0, 0, 0};
    vecs[23] = '{0, 0, 0,  0, 0,  0,  0, 1, 32'h77, 0,   1, 0, 0,   1, 7, 32'h77};
    vecs[24] = '{0, 0, 0,  0, 0,  0,  0, 0, 0,      1,   1, 0, 0,   0, 0, 0};

    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_issue_ready", issue_ready_o, 1'b1);
    check("rst_exu_valid", exu_valid_o, 1'b0);
    check("rst_exu_op", exu_op_o, 96'h0);
    check("rst_result_valid", result_valid_o, 1'b0);
    check("rst_result_id", result_id_o, 4'h0);
    check("rst_result_data", result_data_o, 32'h0);
    check("rst_result_exc", result_exc_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;

    // Single issue/commit, accept=0 rejection, kill, same-cycle commit,
    // unknown-id commit and done-outside-WAIT.
    for (int i = 0; i < 25; i++) begin
      issue_valid_i  = vecs[i].iv;
      issue_accept_i = vecs[i].ia;
      issue_id_i     = vecs[i].iid;
      issue_op_i     = op_of(vecs[i].iid);
      commit_valid_i = vecs[i].cv;
      commit_id_i    = vecs[i].cid;
      commit_kill_i  = vecs[i].ck;
      exu_ready_i    = vecs[i].er;
      exu_done_i     = vecs[i].ed;
      exu_data_i     = vecs[i].edata;
      result_ready_i = vecs[i].rr;
      tick();
      check($sformatf("v%0d_issue_ready", i), issue_ready_o, vecs[i].x_ir);
      check($sformatf("v%0d_exu_valid", i), exu_valid_o, vecs[i].x_ev);
      check($sformatf("v%0d_exu_op", i), exu_op_o, vecs[i].x_ev ? op_of(vecs[i].x_opid) : 96'h0);
      check($sformatf("v%0d_result_valid", i), result_valid_o, vecs[i].x_rv);
      check($sformatf("v%0d_result_id", i), result_id_o, vecs[i].x_rid);
      check($sformatf("v%0d_result_data", i), result_data_o, vecs[i].x_rdata);
      check($sformatf("v%0d_result_exc", i), result_exc_o, 1'b0);
    end
    idle_inputs();

    // Result backpressure: second committed op must not dispatch while held.
    issue_commit(4'h5);
    issue_commit(4'h6);
    drain_one(4'h5, 32'h5555_0005, 5);
    drain_one(4'h6, 32'h6666_0006, 0);

    // Fill to DEPTH, attempt an issue while full, then drain in order.
    for (int k = 0; k < 4; k++) begin
      issue_valid_i  = 1'b1;
      issue_accept_i = 1'b1;
      issue_id_i     = 4'(10 + k);
      issue_op_i     = op_of(4'(10 + k));
      tick();
      check($sformatf("fill%0d_issue_ready", k), issue_ready_o, (k < 3) ? 1'b1 : 1'b0);
    end
    issue_id_i = 4'he;
    issue_op_i = op_of(4'he);
    tick();
    idle_inputs();
    check("full_blocks_issue", issue_ready_o, 1'b0);
    check("full_no_dispatch", exu_valid_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      commit_valid_i = 1'b1;
      commit_id_i    = 4'(10 + k);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      drain_one(4'(10 + k), 32'hC0DE_0000 + 32'(k), 0);
      if (k == 0) check("ready_after_first_pop", issue_ready_o, 1'b1);
    end
    repeat (3) tick();
    check("drained_no_dispatch", exu_valid_o, 1'b0);
    check("drained_issue_ready", issue_ready_o, 1'b1);

`ifdef CVXIF_SCHED_TIMEOUT_EN
    // Silent EXU: RESP with exception after 8 WAIT cycles; late done ignored.
    issue_commit(4'h8);
    wait_dispatch("to_dispatch");
    exu_ready_i = 1'b1;
    tick();
    exu_ready_i = 1'b0;
    for (int c = 1; c < 8; c++) begin
      tick();
      check($sformatf("to_wait%0d_rvalid", c), result_valid_o, 1'b0);
    end
    tick();
    check("to_rvalid", result_valid_o, 1'b1);
    check("to_rid", result_id_o, 4'h8);
    check("to_rdata", result_data_o, 32'h0);
    check("to_rexc", result_exc_o, 1'b1);
    exu_done_i = 1'b1;
    exu_data_i = 32'hBAD0_BAD0;
    tick();
    exu_done_i = 1'b0;
    exu_data_i = '0;
    check("late_done_rdata", result_data_o, 32'h0);
    check("late_done_rexc", result_exc_o, 1'b1);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("to_rvalid_low", result_valid_o, 1'b0);
    check("to_rexc_low", result_exc_o, 1'b0);
`endif

    // Reset while an op is in WAIT.
    issue_commit(4'h2);
    wait_dispatch("rstw_dispatch");
    exu_ready_i = 1'b1;
    tick();
    exu_ready_i = 1'b0;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("rstw_issue_ready", issue_ready_o, 1'b1);
    check("rstw_exu_valid", exu_valid_o, 1'b0);
    check("rstw_exu_op", exu_op_o, 96'h0);
    check("rstw_result_valid", result_valid_o, 1'b0);
    check("rstw_result_id", result_id_o, 4'h0);
    check("rstw_result_data", result_data_o, 32'h0);
    check("rstw_result_exc", result_exc_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    exu_done_i = 1'b1;
    exu_data_i = 32'h1234_ABCD;
    tick();
    idle_inputs();
    repeat (2) tick();
    check("post_rst_result_valid", result_valid_o, 1'b0);
    check("post_rst_exu_valid", exu_valid_o, 1'b0);
    check("post_rst_issue_ready", issue_ready_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
